// File: rtl/boron_encrypt.sv
// Iterative BORON encryptor: 64-bit block, 80-bit key, 25 rounds at one round per
// clock, then a final whitening XOR with the 26th round key.

module enc_sbox4 (
  input  logic [3:0] a,
  output logic [3:0] y
);
  always_comb begin
    y = 4'h0;
    case (a)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
  end
endmodule

module enc_sbox_layer (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  for (genvar n = 0; n < 16; n++) begin : g_nib
    enc_sbox4 u_sbox (.a(din[4*n +: 4]), .y(dout[4*n +: 4]));
  end
endmodule

// Swaps adjacent 16-bit words: {w3,w2,w1,w0} -> {w2,w3,w0,w1}.
module enc_block_shuffle (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  assign dout = {din[47:32], din[63:48], din[15:0], din[31:16]};
endmodule

// Rotates each 16-bit word left by 1, 4, 7 and 9 (w0..w3).
module enc_round_permutation (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  logic [15:0] w0, w1, w2, w3;
  assign {w3, w2, w1, w0} = din;
  assign dout = {{w3[6:0], w3[15:7]}, {w2[8:0], w2[15:9]},
                 {w1[11:0], w1[15:12]}, {w0[14:0], w0[15]}};
endmodule

module enc_xor_operation (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  logic [15:0] w0, w1, w2, w3;
  assign {w3, w2, w1, w0} = din;
  assign dout = {w3 ^ w2, w2, w1 ^ w0, w0};
endmodule

module enc_key_scheduler (
  input  logic [79:0] key_in,
  input  logic [4:0]  rc,
  output logic [79:0] key_out
);
  logic [79:0] rot;
  logic [3:0]  sub;
  assign rot = {key_in[66:0], key_in[79:67]};
  enc_sbox4 u_sbox (.a(rot[3:0]), .y(sub));
  assign key_out = {rot[79:64], rot[63:59] ^ rc, rot[58:4], sub};
endmodule

module boron_encrypt #(
  parameter int NUM_ROUNDS = 25,
  parameter int RC_W       = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  plain_text,
  input  logic [79:0]  master_key,
  input  logic         enc_start,
  output logic         busy,
  output logic [63:0]  cipher_text,
  output logic         enc_done
);
  // Handshake: enc_start is a request taken only in IDLE (busy=0), including the
  // cycle enc_done is high; enc_done is a one-cycle pulse with cipher_text valid
  // from that cycle until the next enc_done. Requests seen while busy are dropped.
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t            state, next_state;
  logic [63:0]       state_reg;
  logic [79:0]       key_reg;
  logic [RC_W-1:0]   round_counter;
  logic              load, round_en, finish, bad_count;

  logic [63:0] sbox_out, bs_out, rp_out, round_out;
  logic [79:0] key_next;

  enc_sbox_layer        u_sbox (.din(state_reg ^ key_reg[63:0]), .dout(sbox_out));
  enc_block_shuffle     u_bs   (.din(sbox_out), .dout(bs_out));
  enc_round_permutation u_rp   (.din(bs_out),   .dout(rp_out));
  enc_xor_operation     u_xor  (.din(rp_out),   .dout(round_out));
  enc_key_scheduler     u_ks   (.key_in(key_reg), .rc(round_counter[4:0]), .key_out(key_next));

  assign bad_count = (round_counter > RC_W'(NUM_ROUNDS)) || (round_counter == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enc_start) next_state = ROUND;
      ROUND: begin
        if (bad_count)                                 next_state = IDLE;
        else if (round_counter == RC_W'(NUM_ROUNDS))   next_state = FINAL;
      end
      FINAL: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    round_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:    load     = enc_start;
      ROUND:   round_en = !bad_count;
      FINAL:   finish   = 1'b1;
      default: ;
    endcase
  end

  // An out-of-range counter in ROUND drops back to idle without producing output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= '0;
      key_reg       <= '0;
      round_counter <= '0;
      busy          <= 1'b0;
      enc_done      <= 1'b0;
      cipher_text   <= '0;
    end else begin
      enc_done <= finish;
      if (load) begin
        state_reg     <= plain_text;
        key_reg       <= master_key;
        round_counter <= RC_W'(1);
        busy          <= 1'b1;
      end else if (round_en) begin
        state_reg     <= round_out;
        key_reg       <= key_next;
        round_counter <= round_counter + RC_W'(1);
      end else if (finish) begin
        cipher_text   <= state_reg ^ key_reg[63:0];
        busy          <= 1'b0;
        round_counter <= '0;
      end else if (state == ROUND) begin
        busy          <= 1'b0;
        round_counter <= '0;
      end
    end
  end
endmodule

// File: doc/boron_encrypt.md
Name: boron_encrypt

Overview:
- Iterative BORON block-cipher encryptor: 64-bit plaintext, 80-bit master key, 25 rounds plus a final key whitening step.
- Performs one round per clock.
- Forward counterpart of the decryption block. Reuses the shared forward key scheduler `enc_key_scheduler` and the enc_* round primitives: `enc_sbox_layer`, `enc_block_shuffle`, `enc_round_permutation`, `enc_xor_operation`.
- Sits beside the decryptor in the cipher core and is driven by the same start/done control style.

Parameters:
- NUM_ROUNDS, 25, number of full rounds. Fixed by the BORON spec; only 25 is verified.
- RC_W, 5, width of the round counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- plain_text  input  64  block to encrypt; sampled only on the accept cycle.
- master_key  input  80  key; sampled only on the accept cycle.
- enc_start  input  1  request to start; honoured only when idle.
- busy  output  1  high while an encryption is in progress.
- cipher_text  output  64  result; holds until the next completion.
- enc_done  output  1  one-cycle pulse when cipher_text updates.

Behaviour:
- Reset values:
  - STATE=IDLE, busy=0, enc_done=0, cipher_text=64'h0, round_counter=0.
  - state_reg and key_reg are cleared to 0.
  - Reset mid-operation aborts immediately. No enc_done pulse; cipher_text is cleared to 0.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - enc_done is low except in the cycle it is pulsed (see FINAL).
  - If enc_start=1 (accept cycle T): state_reg<=plain_text, key_reg<=master_key, round_counter<=1, STATE<=ROUND, busy<=1.
  - If enc_start=0: nothing changes.
- ROUND, with i = round_counter, 1..25, one per cycle:
  - state_reg <= XOR_OP(RP(BS(SBOX(state_reg ^ key_reg[63:0])))).
  - key_reg <= KS(key_reg, i).
  - round_counter <= i+1.
  - When i==25: STATE<=FINAL.
- KS (enc_key_scheduler):
  - Rotate the 80-bit key left by 13.
  - Apply the BORON S-box to bits [3:0].
  - XOR the 5-bit round counter into bits [63:59].
- FINAL (one cycle):
  - cipher_text <= state_reg ^ key_reg[63:0], using the 26th round key.
  - enc_done <= 1, busy <= 0, STATE <= IDLE, round_counter <= 0.
- Latency: enc_done and the new cipher_text are visible in cycle T+27, i.e. registered at the edge ending cycle T+26, 27 cycles after the accept cycle.
  - A new accept is possible in the same cycle enc_done is high, giving back-to-back throughput of one block per 27 cycles.
- enc_start while busy=1 is ignored: no queuing, no error, no effect on the in-flight block.
- plain_text and master_key may change freely after the accept cycle; only the registered copies are used.
- enc_done is exactly one cycle wide. It deasserts the next cycle regardless of enc_start.
- round_counter never exceeds 25 in ROUND. Values 26–31 are unreachable; an implementation that reaches them must return to IDLE.
- Purely single-cycle combinational round path; no multicycle paths.

Test Plan:
- Reset then idle: reset 1 for 2 cycles, release, enc_start=0 for 50 cycles -> busy=0, enc_done=0, cipher_text=64'h0 throughout.
- Golden vectors: (plain=64'h0, key=80'h0), (plain=64'hFFFF_FFFF_FFFF_FFFF, key=80'hFFFF_FFFF_FFFF_FFFF_FFFF), and (plain=64'h0123_4567_89AB_CDEF, key=80'h0123_4567_89AB_CDEF_0123) -> cipher_text equals the team C reference model. enc_done rises exactly 27 cycles after the accept cycle. busy is high for exactly 26 cycles.
- Round-trip: 1000 random plain/key pairs -> encrypt, then feed cipher_text and the same key to the decryptor -> recovered plain_text equals the original every time.
- Ignored start: pulse enc_start at T+5 and T+20 with different plain_text/master_key values -> result matches the first block only; exactly one enc_done pulse.
- Back-to-back: assert enc_start in the enc_done cycle with a new block -> second result correct; enc_done pulses 27 cycles apart; busy low only in the cycle enc_done is high.
- Reset mid-operation: reset for 1 cycle at T+12 -> no enc_done; busy=0 and cipher_text=0 next cycle. A fresh encryption started afterwards gives the golden result.
